// File: rtl/inst_rom.sv
// ============================================================================
//  Module   : inst_rom
//  Purpose  : Instruction memory with a combinational fetch port and a
//             byte-serial, big-endian boot loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_rom #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        loading,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         wbuf_q, wbuf_d;
  logic                full_q, full_d;

  logic [31:0]         wbuf_ins;
  logic                mem_we;
  logic [31:0]         mem [DEPTH];

  // Byte merged into the word buffer; starting a word zeroes the lower bytes,
  // which also gives zero padding when ld_last ends a partial word.
  always_comb begin
    wbuf_ins = (bcnt_q == 2'd0) ? 32'h0 : wbuf_q;
    case (bcnt_q)
      2'd0:    wbuf_ins[31:24] = ld_byte;
      2'd1:    wbuf_ins[23:16] = ld_byte;
      2'd2:    wbuf_ins[15:8]  = ld_byte;
      default: wbuf_ins[7:0]   = ld_byte;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    bcnt_d  = bcnt_q;
    wbuf_d  = wbuf_q;
    full_d  = full_q;
    mem_we  = 1'b0;
    if (ld_start) begin
      state_d = LOAD;
      wptr_d  = '0;
      bcnt_d  = 2'd0;
      wbuf_d  = 32'h0;
      full_d  = 1'b0;
    end else if (state_q == LOAD && ld_valid) begin
      if (full_q) begin
        state_d = ERR;
      end else begin
        wbuf_d = wbuf_ins;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3 || ld_last) begin
          mem_we = 1'b1;
          if (&wptr_q) full_d = 1'b1;
          else         wptr_d = wptr_q + ADDR_W'(1);
        end
        if (ld_last) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      bcnt_q  <= 2'd0;
      wbuf_q  <= 32'h0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      wbuf_q  <= wbuf_d;
      full_q  <= full_d;
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= wbuf_ins;
  end

  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign ld_ready = (state_q == LOAD);
  assign loading  = (state_q == LOAD);
  assign ld_done  = (state_q == DONE);
  assign ld_err   = (state_q == ERR);
  assign inst     = (ce && state_q != LOAD) ? mem[addr[ADDR_W+1:2]] : 32'h0;

endmodule

`default_nettype wire
